// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package cpu_mem_pkg;
   localparam int ADDR_W_DFLT = 6;
   localparam int DATA_W_DFLT = 16;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT
   } arb_state_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_LDR = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the pointed master wins if requesting, else the other.
// Purely combinational; the caller owns the pointer.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic       vld_o,
   output logic       win_o
);
   assign vld_o = |req_i;
   assign win_o = req_i[ptr_i] ? ptr_i : ~ptr_i;
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data RAM, one command in flight.
// Strobes and grant appear the cycle after the IDLE sample; read data returns RD_LAT+1 cycles after issue.
module ram_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_write,
   output logic              ram_read,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_out,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              busy
);
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT);

   arb_state_t        state_q;
   logic              ptr_q;
   logic              win_q;
   logic              we_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        gnt_q;
   logic [1:0]        rvalid_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;
   logic              ram_write_q;
   logic              ram_read_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_dout_q;
   logic              busy_q;

   logic              pick_vld;
   logic              pick_win;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_pick2 u_pick (
      .req_i ({m1_req, m0_req}),
      .ptr_i (ptr_q),
      .vld_o (pick_vld),
      .win_o (pick_win)
   );

   assign sel_we    = pick_win ? m1_we    : m0_we;
   assign sel_addr  = pick_win ? m1_addr  : m0_addr;
   assign sel_wdata = pick_win ? m1_wdata : m0_wdata;

   // Strobes, address and grant are loaded on the IDLE->ISSUE edge so they are
   // registered and visible for exactly the ISSUE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         ptr_q       <= M_CPU;
         win_q       <= M_CPU;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         gnt_q       <= 2'b00;
         rvalid_q    <= 2'b00;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         ram_write_q <= 1'b0;
         ram_read_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_dout_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         gnt_q       <= 2'b00;
         rvalid_q    <= 2'b00;
         ram_write_q <= 1'b0;
         ram_read_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_dout_q  <= '0;
         case (state_q)
            ARB_IDLE: begin
               if (pick_vld) begin
                  win_q           <= pick_win;
                  we_q            <= sel_we;
                  gnt_q[pick_win] <= 1'b1;
                  ram_write_q     <= sel_we;
                  ram_read_q      <= ~sel_we;
                  ram_addr_q      <= sel_addr;
                  ram_dout_q      <= sel_we ? sel_wdata : '0;
                  busy_q          <= 1'b1;
                  state_q         <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               ptr_q <= ~win_q;
               if (we_q) begin
                  busy_q  <= 1'b0;
                  state_q <= ARB_IDLE;
               end else begin
                  cnt_q   <= LAT_INIT;
                  state_q <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               // cnt_q == 1 marks the cycle in which ram_data_in is valid
               if (cnt_q == CNT_W'(1)) begin
                  if (win_q == M_LDR) m1_rdata_q <= ram_data_in;
                  else                m0_rdata_q <= ram_data_in;
                  rvalid_q[win_q] <= 1'b1;
                  cnt_q           <= '0;
                  busy_q          <= 1'b0;
                  state_q         <= ARB_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign m0_gnt       = gnt_q[0];
   assign m1_gnt       = gnt_q[1];
   assign m0_rvalid    = rvalid_q[0];
   assign m1_rvalid    = rvalid_q[1];
   assign m0_rdata     = m0_rdata_q;
   assign m1_rdata     = m1_rdata_q;
   assign ram_write    = ram_write_q;
   assign ram_read     = ram_read_q;
   assign ram_addr     = ram_addr_q;
   assign ram_data_out = ram_dout_q;
   assign busy         = busy_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Two arbiter instances (RD_LAT 1 and 3) on shared master stimulus, each with its own RAM
// and a transaction-level scheduling model checked every cycle, plus directed scenario checks.
module tb_ram_port_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [5:0]  m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;

   logic [1:0]  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write, ram_read, busy;
   logic [5:0]  ram_addr [2];
   logic [15:0] ram_data_out [2];
   logic [15:0] ram_data_in [2];
   logic [15:0] m0_rdata [2];
   logic [15:0] m1_rdata [2];

   int total = 0;
   int bad = 0;

   function automatic logic [15:0] init_val(input logic [5:0] a);
      return (a == 6'h3F) ? 16'h1234 : (({10'd0, a} * 16'h0101) ^ 16'h5A00);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = (g == 0) ? 1 : 3;
      logic [15:0] mem [64];
      logic [15:0] pipe [8];

      ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .RD_LAT(L)) u_dut (
         .clk          (clk),
         .reset        (reset),
         .m0_req       (m0_req),
         .m0_we        (m0_we),
         .m0_addr      (m0_addr),
         .m0_wdata     (m0_wdata),
         .m0_gnt       (m0_gnt[g]),
         .m0_rvalid    (m0_rvalid[g]),
         .m0_rdata     (m0_rdata[g]),
         .m1_req       (m1_req),
         .m1_we        (m1_we),
         .m1_addr      (m1_addr),
         .m1_wdata     (m1_wdata),
         .m1_gnt       (m1_gnt[g]),
         .m1_rvalid    (m1_rvalid[g]),
         .m1_rdata     (m1_rdata[g]),
         .ram_write    (ram_write[g]),
         .ram_read     (ram_read[g]),
         .ram_addr     (ram_addr[g]),
         .ram_data_out (ram_data_out[g]),
         .ram_data_in  (ram_data_in[g]),
         .busy         (busy[g])
      );

      // RAM: read data valid L cycles after the read-strobe cycle, garbage otherwise
      always @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(6'(i));
         end else if (ram_write[g]) begin
            mem[ram_addr[g]] <= ram_data_out[g];
         end
         pipe[0] <= ram_read[g] ? mem[ram_addr[g]] : 16'($urandom);
         for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      end
      assign ram_data_in[g] = pipe[L-1];

      // Reference: at each edge ending cycle cyc, predict outputs for cycle cyc+1
      int          cyc = 0;
      int          idle_from = 0;
      int          rd_at = 0;
      bit          valid_m = 1'b0;
      bit          ptr, pend, rd_w, mw, mwe;
      logic [5:0]  rd_addr, maddr;
      logic [15:0] mdat;
      logic [15:0] ref_mem [64];
      logic [15:0] e_rdata [2];
      logic [1:0]  e_gnt, e_rv;
      logic        e_wr, e_rd, e_busy;
      logic [5:0]  e_addr;
      logic [15:0] e_dout;

      always @(posedge clk) begin
         e_gnt = 2'b00; e_rv = 2'b00; e_wr = 1'b0; e_rd = 1'b0;
         e_addr = 6'h00; e_dout = 16'h0000;
         if (reset) begin
            valid_m = 1'b1; ptr = 1'b0; pend = 1'b0; idle_from = cyc + 1;
            e_rdata[0] = 16'h0000; e_rdata[1] = 16'h0000;
            for (int i = 0; i < 64; i++) ref_mem[i] = init_val(6'(i));
         end else if (valid_m) begin
            if (pend && rd_at == cyc + 1) begin
               e_rv[rd_w] = 1'b1;
               e_rdata[rd_w] = ref_mem[rd_addr];
               pend = 1'b0;
            end
            if (cyc >= idle_from && (m0_req || m1_req)) begin
               mw    = (ptr ? m1_req : m0_req) ? ptr : !ptr;
               mwe   = mw ? m1_we : m0_we;
               maddr = mw ? m1_addr : m0_addr;
               mdat  = mw ? m1_wdata : m0_wdata;
               e_gnt[mw] = 1'b1;
               e_addr = maddr;
               ptr = !mw;
               if (mwe) begin
                  e_wr = 1'b1; e_dout = mdat; ref_mem[maddr] = mdat;
                  idle_from = cyc + 2;
               end else begin
                  e_rd = 1'b1; pend = 1'b1; rd_w = mw; rd_addr = maddr;
                  rd_at = cyc + 2 + L; idle_from = cyc + 2 + L;
               end
            end
         end
         e_busy = (cyc + 1 < idle_from);
         cyc++;
      end
   end

   task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (g_inst[0].valid_m) begin
         cmp("i0_ram", 64'({ram_write[0], ram_read[0], ram_addr[0], ram_data_out[0]}),
             64'({g_inst[0].e_wr, g_inst[0].e_rd, g_inst[0].e_addr, g_inst[0].e_dout}));
         cmp("i0_ctl", 64'({m0_gnt[0], m1_gnt[0], m0_rvalid[0], m1_rvalid[0], busy[0]}),
             64'({g_inst[0].e_gnt[0], g_inst[0].e_gnt[1], g_inst[0].e_rv[0], g_inst[0].e_rv[1], g_inst[0].e_busy}));
         cmp("i0_rdata", 64'({m0_rdata[0], m1_rdata[0]}),
             64'({g_inst[0].e_rdata[0], g_inst[0].e_rdata[1]}));
      end
      if (g_inst[1].valid_m) begin
         cmp("i1_ram", 64'({ram_write[1], ram_read[1], ram_addr[1], ram_data_out[1]}),
             64'({g_inst[1].e_wr, g_inst[1].e_rd, g_inst[1].e_addr, g_inst[1].e_dout}));
         cmp("i1_ctl", 64'({m0_gnt[1], m1_gnt[1], m0_rvalid[1], m1_rvalid[1], busy[1]}),
             64'({g_inst[1].e_gnt[0], g_inst[1].e_gnt[1], g_inst[1].e_rv[0], g_inst[1].e_rv[1], g_inst[1].e_busy}));
         cmp("i1_rdata", 64'({m0_rdata[1], m1_rdata[1]}),
             64'({g_inst[1].e_rdata[0], g_inst[1].e_rdata[1]}));
      end
   endtask

   task automatic chk_zero(input string tag);
      cmp({tag, "_i0"}, 64'({m0_gnt[0], m1_gnt[0], m0_rvalid[0], m1_rvalid[0], ram_write[0], ram_read[0],
                             busy[0], ram_addr[0], ram_data_out[0]}), 64'd0);
      cmp({tag, "_i0_rd"}, 64'({m0_rdata[0], m1_rdata[0]}), 64'd0);
      cmp({tag, "_i1"}, 64'({m0_gnt[1], m1_gnt[1], m0_rvalid[1], m1_rvalid[1], ram_write[1], ram_read[1],
                             busy[1], ram_addr[1], ram_data_out[1]}), 64'd0);
      cmp({tag, "_i1_rd"}, 64'({m0_rdata[1], m1_rdata[1]}), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 6'h00; m0_wdata = 16'h0000;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 6'h00; m1_wdata = 16'h0000;
      repeat (3) tick();
      chk_zero("reset");
      reset = 1'b0;
      tick();

      // m0 write alone
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'h05; m0_wdata = 16'hABCD;
      tick();
      m0_req = 1'b0;
      cmp("t1_issue", 64'({ram_write[0], ram_read[0], ram_addr[0], ram_data_out[0], m0_gnt[0], m1_gnt[0], busy[0]}),
          64'({1'b1, 1'b0, 6'h05, 16'hABCD, 1'b1, 1'b0, 1'b1}));
      tick();
      cmp("t1_done", 64'({busy[0], m0_gnt[0], ram_write[0]}), 64'd0);

      // m1 read of 0x3F, RD_LAT=1
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h3F;
      tick();
      m1_req = 1'b0;
      cmp("t2_issue", 64'({ram_read[0], ram_write[0], ram_addr[0], ram_data_out[0], m1_gnt[0]}),
          64'({1'b1, 1'b0, 6'h3F, 16'h0000, 1'b1}));
      tick();
      cmp("t2_wait", 64'({m1_rvalid[0], m0_rvalid[0], busy[0]}), 64'({1'b0, 1'b0, 1'b1}));
      tick();
      cmp("t2_rvalid", 64'({m1_rvalid[0], m0_rvalid[0], m1_rdata[0]}), 64'({1'b1, 1'b0, 16'h1234}));
      repeat (4) tick();

      // both masters hold write requests: strict alternation
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'h10; m0_wdata = 16'h0F0F;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'h20; m1_wdata = 16'hF0F0;
      for (int i = 0; i < 8; i++) begin
         tick();
         cmp("t3_gnt", 64'({m0_gnt[0], m1_gnt[0]}), 64'({i % 4 == 0, i % 4 == 2}));
      end
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (3) tick();

      // RD_LAT=3: m0 read while m1 waits
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h05;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'h21; m1_wdata = 16'h5555;
      tick();
      m0_req = 1'b0;
      cmp("t4_issue", 64'({ram_read[1], m0_gnt[1], m1_gnt[1]}), 64'(3'b110));
      for (int i = 1; i <= 3; i++) begin
         tick();
         cmp("t4_wait", 64'({ram_read[1], ram_write[1], m1_gnt[1], m0_rvalid[1]}), 64'd0);
      end
      tick();
      cmp("t4_rvalid", 64'({m0_rvalid[1], m1_gnt[1], m0_rdata[1]}), 64'({1'b1, 1'b0, 16'hABCD}));
      tick();
      cmp("t4_m1_gnt", 64'({m1_gnt[1], ram_write[1], ram_addr[1], ram_data_out[1]}),
          64'({1'b1, 1'b1, 6'h21, 16'h5555}));
      m1_req = 1'b0;
      repeat (4) tick();

      // reset during an m1 read's WAIT
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h11;
      tick();
      m1_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero("t5_abort");
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'h12; m0_wdata = 16'h1111;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'h13; m1_wdata = 16'h2222;
      tick();
      cmp("t5_first", 64'({m0_gnt[0], m1_gnt[0], m0_gnt[1], m1_gnt[1], m1_rvalid[0], m1_rvalid[1]}),
          64'(6'b101000));
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (3) tick();

      // m1 pulses req only during m0's ISSUE
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'h07; m0_wdata = 16'h7777;
      tick();
      m0_req = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h07;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) m1_req = 1'b0;
         cmp("t6_idle", 64'({m1_gnt[0], busy[0], m1_gnt[1], busy[1]}), 64'd0);
      end

      // random traffic with occasional reset
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 59) == 0);
         if (m0_req && $urandom_range(0, 3) == 0) m0_req = 1'b0;
         else if (!m0_req && $urandom_range(0, 1) == 0) begin
            m0_req = 1'b1; m0_we = 1'($urandom);
            m0_addr = 6'($urandom_range(0, 7)); m0_wdata = 16'($urandom);
         end
         if (m1_req && $urandom_range(0, 3) == 0) m1_req = 1'b0;
         else if (!m1_req && $urandom_range(0, 1) == 0) begin
            m1_req = 1'b1; m1_we = 1'($urandom);
            m1_addr = 6'($urandom_range(0, 7)); m1_wdata = 16'($urandom);
         end
         tick();
      end
      reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
